// File: rtl/radiance_perf_pkg.sv
// Shared types and helpers for the backend performance-counter unit.
// Holds the FSM state enum, the default counter width and a saturating adder.
package radiance_perf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } perf_state_e;

  localparam int DEFAULT_COUNTER_WIDTH = 64;
  localparam int SAT_MAX_WIDTH         = 64;

  // Saturating add clipped to the low 'width' bits (width in 1..64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          width);
    logic [64:0] sum;
    logic [64:0] limit;
    sum = {1'b0, a} + {1'b0, b};
    if (width >= SAT_MAX_WIDTH) begin
      limit = {1'b0, {64{1'b1}}};
    end else begin
      limit = (65'd1 << width) - 65'd1;
    end
    if (sum > limit) begin
      return limit[63:0];
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/perf_counter_unit_popcount.sv
// Combinational popcount of the per-lane retire strobes.
// Output width is just wide enough to hold NUM_LANES.
module perf_popcount #(
  parameter  int NUM_LANES = 4,
  localparam int CNT_W     = $clog2(NUM_LANES + 1)
) (
  input  logic [NUM_LANES-1:0] lanes,
  output logic [CNT_W-1:0]     count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      count = count + CNT_W'(lanes[i]);
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Backend performance counters: retired instructions and active cycles,
// gated by a launch/drain FSM that raises a sticky finished flag.
module perf_counter_unit
  import radiance_perf_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
  parameter int NUM_LANES     = 4,
  parameter int QUIET_CYCLES  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_LANES-1:0]     retire_valid,
  input  logic                     warps_active,
  input  logic                     pipe_busy,
  output logic [COUNTER_WIDTH-1:0] perf_backend_execute_instRetired,
  output logic [COUNTER_WIDTH-1:0] perf_backend_execute_cycle,
  output logic                     finished,
  output logic                     running
);

  localparam int POP_W   = $clog2(NUM_LANES + 1);
  localparam int QUIET_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);

  perf_state_e              state;
  logic [QUIET_W-1:0]       quiet;
  logic [POP_W-1:0]         retire_count;
  logic [COUNTER_WIDTH-1:0] inst_next;
  logic [COUNTER_WIDTH-1:0] cycle_next;
  logic                     counting;

  perf_popcount #(
    .NUM_LANES(NUM_LANES)
  ) u_popcount (
    .lanes(retire_valid),
    .count(retire_count)
  );

  // Saturating next values; only committed while the core is executing.
  always_comb begin
    counting   = (state == RUN) || (state == DRAIN);
    inst_next  = COUNTER_WIDTH'(sat_add(64'(perf_backend_execute_instRetired),
                                        64'(retire_count), COUNTER_WIDTH));
    cycle_next = COUNTER_WIDTH'(sat_add(64'(perf_backend_execute_cycle),
                                        64'd1, COUNTER_WIDTH));
  end

  // FSM plus counter registers; the quiet counter only advances on idle DRAIN cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                            <= IDLE;
      quiet                            <= '0;
      perf_backend_execute_instRetired <= '0;
      perf_backend_execute_cycle       <= '0;
      finished                         <= 1'b0;
      running                          <= 1'b0;
    end else begin
      if (counting) begin
        perf_backend_execute_instRetired <= inst_next;
        perf_backend_execute_cycle       <= cycle_next;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (!warps_active) begin
            state <= DRAIN;
            quiet <= '0;
          end
        end
        DRAIN: begin
          if (warps_active) begin
            state <= RUN;
            quiet <= '0;
          end else if (pipe_busy) begin
            quiet <= '0;
          end else if (quiet == QUIET_LAST) begin
            state    <= DONE;
            quiet    <= '0;
            finished <= 1'b1;
            running  <= 1'b0;
          end else begin
            quiet <= quiet + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench for perf_counter_unit: a 64-bit and an 8-bit instance share
// stimulus; an abstract model queues expected outputs that a monitor checks.
module tb_perf_counter_unit;

  localparam int LANES = 4;
  localparam int QUIET = 16;

  logic             clock;
  logic             reset;
  logic             start;
  logic [LANES-1:0] retire_valid;
  logic             warps_active;
  logic             pipe_busy;
  logic [63:0]      inst_wide, cycle_wide;
  logic [7:0]       inst_narrow, cycle_narrow;
  logic             finished_wide, running_wide, finished_narrow, running_narrow;

  perf_counter_unit #(.COUNTER_WIDTH(64), .NUM_LANES(LANES), .QUIET_CYCLES(QUIET)) dut (
    .clock(clock), .reset(reset), .start(start), .retire_valid(retire_valid),
    .warps_active(warps_active), .pipe_busy(pipe_busy),
    .perf_backend_execute_instRetired(inst_wide),
    .perf_backend_execute_cycle(cycle_wide),
    .finished(finished_wide), .running(running_wide)
  );

  perf_counter_unit #(.COUNTER_WIDTH(8), .NUM_LANES(LANES), .QUIET_CYCLES(QUIET)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .retire_valid(retire_valid),
    .warps_active(warps_active), .pipe_busy(pipe_busy),
    .perf_backend_execute_instRetired(inst_narrow),
    .perf_backend_execute_cycle(cycle_narrow),
    .finished(finished_narrow), .running(running_narrow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    longint inst;
    longint cyc;
    bit     fin;
    bit     run;
  } expect_t;

  expect_t expQ[$];
  int      vectors = 0;
  int      miscompares = 0;

  // Abstract model: phase 0 idle, 1 executing with warps, 2 draining, 3 finished.
  int     mPhase = 0;
  int     mIdleStreak = 0;
  longint mInst = 0;
  longint mCyc = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [LANES-1:0] rv,
                               input logic w, input logic b);
    expect_t e;
    @(negedge clock);
    reset        = r;
    start        = s;
    retire_valid = rv;
    warps_active = w;
    pipe_busy    = b;
    if (r) begin
      mPhase = 0; mIdleStreak = 0; mInst = 0; mCyc = 0;
    end else begin
      if (mPhase == 1 || mPhase == 2) begin
        mCyc  += 1;
        mInst += $countones(rv);
      end
      if (mPhase == 0 && s) mPhase = 1;
      else if (mPhase == 1 && !w) begin mPhase = 2; mIdleStreak = 0; end
      else if (mPhase == 2) begin
        if (w) begin mPhase = 1; mIdleStreak = 0; end
        else if (b) mIdleStreak = 0;
        else begin
          mIdleStreak += 1;
          if (mIdleStreak == QUIET) mPhase = 3;
        end
      end
    end
    e.inst = mInst;
    e.cyc  = mCyc;
    e.fin  = (mPhase == 3);
    e.run  = (mPhase == 1 || mPhase == 2);
    expQ.push_back(e);
  endtask

  task automatic runCycles(input int n, input logic s, input logic [LANES-1:0] rv,
                           input logic w, input logic b);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, s, rv, w, b);
  endtask

  // Monitor: compares every queued expectation just after the edge it describes.
  initial begin
    expect_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("inst64", inst_wide, 64'(e.inst));
        checkOutput("cycle64", cycle_wide, 64'(e.cyc));
        checkOutput("finished64", 64'(finished_wide), 64'(e.fin));
        checkOutput("running64", 64'(running_wide), 64'(e.run));
        checkOutput("inst8", 64'(inst_narrow), 64'((e.inst > 255) ? 255 : e.inst));
        checkOutput("cycle8", 64'(cycle_narrow), 64'((e.cyc > 255) ? 255 : e.cyc));
        checkOutput("finished8", 64'(finished_narrow), 64'(e.fin));
        checkOutput("running8", 64'(running_narrow), 64'(e.run));
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; retire_valid = '0; warps_active = 1'b1; pipe_busy = 1'b1;
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'hF, 1'b1, 1'b1);

    // Retires with no launch are dropped.
    runCycles(20, 1'b0, 4'hF, 1'b1, 1'b1);

    // Launch, 10 full-retire cycles, then go idle until finished, then poke start in DONE.
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b1, 1'b1);
    runCycles(10, 1'b0, 4'hF, 1'b1, 1'b1);
    runCycles(QUIET + 4, 1'b0, '0, 1'b0, 1'b0);
    runCycles(3, 1'b1, 4'hF, 1'b1, 1'b1);
    runCycles(3, 1'b0, 4'hF, 1'b0, 1'b0);

    // Reset inside DRAIN at cycle 37, then relaunch.
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, '0, 1'b1, 1'b1);
    runCycles(34, 1'b0, 4'h3, 1'b1, 1'b1);
    runCycles(1, 1'b0, 4'h1, 1'b0, 1'b1);
    runCycles(2, 1'b0, 4'h1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b1, 1'b1);
    runCycles(3, 1'b0, 4'h5, 1'b1, 1'b1);

    // Busy pulse at quiet 15 restarts the window; warps returning goes back to RUN.
    runCycles(1, 1'b0, 4'h0, 1'b0, 1'b0);
    runCycles(QUIET - 1, 1'b0, 4'h2, 1'b0, 1'b0);
    runCycles(1, 1'b0, 4'h0, 1'b0, 1'b1);
    runCycles(QUIET - 1, 1'b0, 4'h0, 1'b0, 1'b0);
    runCycles(2, 1'b0, 4'h8, 1'b1, 1'b0);
    runCycles(QUIET + 3, 1'b0, 4'h0, 1'b0, 1'b0);

    // Saturation of the 8-bit instance.
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b1, 1'b1);
    runCycles(70, 1'b0, 4'hF, 1'b1, 1'b1);

    // Randomized traffic with occasional resets and launches.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 9) == 0),
                    LANES'($urandom),
                    ($urandom_range(0, 9) != 0) ? (i % 80 < 40) : ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clock);
    #2;
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
